kernel_ad_sequencer: RTL and testbench
======================================

Name: kernel_ad_sequencer

Overview:
Avalon-MM slave that sequences conversions on the external parallel ADC whose control lines are currently driven by software through the AD control PIO. It generates CONVST/CS/RD timing, waits on the ADC BUSY line, and captures samples into a small FIFO. It runs in single-shot or periodic mode, removing bit-banged ADC control from the Nios II software path.

Parameters:
DATA_W, 12, ADC sample width (1..16)
FIFO_AW, 3, FIFO address bits; depth = 2**FIFO_AW = 8
CONV_W, 2, ad_convst_n low pulse width in clk cycles (>=1)
RD_W, 3, ad_rd_n low width in clk cycles (>=1); data sampled on last low cycle
TIMEOUT, 255, max clk cycles spent waiting for BUSY to fall

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  2  register select
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
read_n  in  1  active-low read strobe (used only for FIFO pop)
writedata  in  32  write data
readdata  out  32  combinational read data, zero wait states
ad_convst_n  out  1  ADC conversion start, active low
ad_cs_n  out  1  ADC chip select, active low
ad_rd_n  out  1  ADC read strobe, active low
ad_busy  in  1  ADC busy, asynchronous, 2-FF synchronised internally
ad_data  in  DATA_W  ADC parallel data bus
irq  out  1  level interrupt: IRQ_EN & FIFO non-empty

Behaviour:
- Clock/reset: single clk domain. reset_n asserted asynchronously clears all state; ad_convst_n/ad_cs_n/ad_rd_n=1, irq=0, FSM=IDLE, FIFO empty, all regs 0. Reset mid-conversion aborts immediately, no sample stored.
- Register map (write = chipselect & ~write_n):
  0 CTRL: bit0 ENABLE (periodic), bit1 START (write-1 single shot, self-clearing, reads 0), bit2 IRQ_EN.
  1 PERIOD: bits[15:0] trigger period in clk cycles; 0 or 1 treated as "back-to-back".
  2 DATA (read only): {bit31 VALID, zeros, sample[DATA_W-1:0]}; empty FIFO reads 0. Pop occurs on the clock edge where chipselect & ~read_n & address==2 & non-empty.
  3 STATUS: bit0 BUSY (FSM != IDLE), bits[7:4] FIFO count (0..8), bit8 OVERFLOW, bit9 TIMEOUT_ERR, bit10 MISSED. Sticky bits cleared by writing 1 to their position; set takes priority over clear in the same cycle.
- Period timer: counts down while ENABLE=1; reloads with PERIOD-1 on reaching 0 and emits trigger. Writing ENABLE 0->1 reloads and triggers immediately. ENABLE=0 holds timer at reload.
- Trigger sources: START write or period trigger. Trigger while FSM != IDLE is dropped and sets MISSED (START included). Disabling mid-conversion lets current conversion finish.
- FSM:
  IDLE: on trigger -> CONV.
  CONV: ad_convst_n=0 for CONV_W cycles -> WAIT.
  WAIT: minimum 3 cycles dwell (synchroniser latency), then -> READ when synced busy=0; if TIMEOUT cycles elapse in WAIT, set TIMEOUT_ERR and -> READ anyway.
  READ: ad_cs_n=0 and ad_rd_n=0 for RD_W cycles; ad_data registered on last cycle -> STORE.
  STORE: push sample (one cycle) -> IDLE.
- Trigger-to-first-convst latency: 1 cycle (convst low in cycle after trigger edge). Outputs are registered, glitch-free.
- FIFO: 8-entry, first-word-fall-through for readdata. Push when full is dropped and sets OVERFLOW, unless a pop occurs in the same cycle, in which case push is accepted and count stays 8. Simultaneous push/pop on non-full FIFO keeps count unchanged. Pointers wrap modulo depth.
- irq combinational from registered IRQ_EN and count != 0.

Test Plan:
- Reset: reset_n=0 mid-READ -> ad_cs_n=ad_rd_n=ad_convst_n=1 same cycle, STATUS=0, DATA reads 0.
- Single shot: write CTRL=0x2, ad_busy high 10 cycles, ad_data=0xABC -> convst low 2 cycles, rd low 3 cycles, DATA reads 0x80000ABC, count 1->0 after read.
- Periodic: PERIOD=100, ENABLE=1, busy 5 cycles -> convst falling edges exactly 100 cycles apart, no MISSED.
- Overflow: 9 conversions with no reads -> count=8, OVERFLOW=1, first 8 samples read back in order; write 0x100 to STATUS clears OVERFLOW.
- Timeout: ad_busy stuck high -> READ entered 255 cycles after WAIT entry, TIMEOUT_ERR=1, sample stored.
- Missed/simultaneous: PERIOD=4 with busy 20 cycles -> MISSED=1; pop on same edge as push when full -> count stays 8, OVERFLOW stays 0.

Source files
------------

// File: rtl/kernel_ad_sequencer_if.sv
// Avalon-MM slave bus bundle for the ADC sequencer register window.
interface kernel_ad_sequencer_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, read_n, writedata,
                  input  readdata);
  modport slave  (input  address, chipselect, write_n, read_n, writedata,
                  output readdata);
endinterface

// File: rtl/kernel_ad_sequencer.sv
// Parallel ADC conversion sequencer: CONVST/CS/RD timing, BUSY wait with
// timeout, single-shot or periodic triggering, 8-deep sample FIFO.
module kernel_ad_sequencer #(
  parameter int DATA_W  = 12,
  parameter int FIFO_AW = 3,
  parameter int CONV_W  = 2,
  parameter int RD_W    = 3,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  kernel_ad_sequencer_if.slave  bus,
  output logic                  ad_convst_n,
  output logic                  ad_cs_n,
  output logic                  ad_rd_n,
  input  logic                  ad_busy,
  input  logic [DATA_W-1:0]     ad_data,
  output logic                  irq
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CNTW  = FIFO_AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_CONV, S_WAIT, S_READ, S_STORE} state_t;

  state_t             r_state, w_nxt;
  logic [15:0]        r_cnt, r_period, r_timer, w_reload;
  logic               r_enable, r_irq_en, r_ovf, r_tmo, r_missed;
  logic               r_busy_s1, r_busy_s2;
  logic               r_convst_n, r_cs_n, r_rd_n;
  logic [DATA_W-1:0]  r_sample;
  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wptr, r_rptr;
  logic [CNTW-1:0]    r_count;
  logic w_wr0, w_wr1, w_wr3, w_start, w_en_rise, w_ptrig, w_trig, w_tmo_set;
  logic w_push, w_pop, w_full, w_push_ok, w_ovf_set, w_missed_set;
  logic w_unused;

  assign w_wr0     = bus.chipselect & ~bus.write_n & (bus.address == 2'd0);
  assign w_wr1     = bus.chipselect & ~bus.write_n & (bus.address == 2'd1);
  assign w_wr3     = bus.chipselect & ~bus.write_n & (bus.address == 2'd3);
  assign w_start   = w_wr0 & bus.writedata[1];
  assign w_en_rise = w_wr0 & bus.writedata[0] & ~r_enable;
  // PERIOD of 0 or 1 both collapse to a zero reload: trigger every cycle
  assign w_reload  = (r_period <= 16'd1) ? 16'd0 : r_period - 16'd1;
  assign w_ptrig   = r_enable & (r_timer == 16'd0);
  assign w_trig    = w_start | w_en_rise | w_ptrig;
  assign w_missed_set = w_trig & (r_state != S_IDLE);

  assign w_push    = (r_state == S_STORE);
  assign w_pop     = bus.chipselect & ~bus.read_n & (bus.address == 2'd2) & (r_count != '0);
  assign w_full    = (r_count == CNTW'(DEPTH));
  // a pop on the same edge frees the slot the push needs
  assign w_push_ok = w_push & (~w_full | w_pop);
  assign w_ovf_set = w_push & w_full & ~w_pop;

  assign ad_convst_n = r_convst_n;
  assign ad_cs_n     = r_cs_n;
  assign ad_rd_n     = r_rd_n;
  assign irq         = r_irq_en & (r_count != '0);
  assign w_unused    = &{1'b0, bus.writedata[31:16]};

  // control/period registers and sticky status (set wins over clear)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_enable <= 1'b0; r_irq_en <= 1'b0; r_period <= '0;
      r_ovf <= 1'b0; r_tmo <= 1'b0; r_missed <= 1'b0;
    end else begin
      if (w_wr0) begin
        r_enable <= bus.writedata[0];
        r_irq_en <= bus.writedata[2];
      end
      if (w_wr1) r_period <= bus.writedata[15:0];
      r_ovf    <= w_ovf_set    | (r_ovf    & ~(w_wr3 & bus.writedata[8]));
      r_tmo    <= w_tmo_set    | (r_tmo    & ~(w_wr3 & bus.writedata[9]));
      r_missed <= w_missed_set | (r_missed & ~(w_wr3 & bus.writedata[10]));
    end
  end

  // period timer: parked at reload while disabled, reload on enable and on expiry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                        r_timer <= '0;
    else if (w_en_rise || !r_enable || r_timer == 16'd0) r_timer <= w_reload;
    else                                                 r_timer <= r_timer - 16'd1;
  end

  // BUSY comes from the ADC clock domain; two-flop synchroniser
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin r_busy_s1 <= 1'b0; r_busy_s2 <= 1'b0; end
    else          begin r_busy_s1 <= ad_busy; r_busy_s2 <= r_busy_s1; end
  end

  // FSM state register, per-state cycle counter and sample capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE; r_cnt <= '0; r_sample <= '0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= (w_nxt != r_state) ? 16'd0 : r_cnt + 16'd1;
      if (r_state == S_READ && r_cnt == 16'(RD_W - 1)) r_sample <= ad_data;
    end
  end

  // next-state logic; WAIT dwells 3 cycles so the synchroniser reflects this conversion
  always_comb begin
    w_nxt     = r_state;
    w_tmo_set = 1'b0;
    case (r_state)
      S_IDLE:  if (w_trig) w_nxt = S_CONV;
      S_CONV:  if (r_cnt == 16'(CONV_W - 1)) w_nxt = S_WAIT;
      S_WAIT:  if (r_cnt >= 16'd2 && !r_busy_s2) w_nxt = S_READ;
               else if (r_cnt >= 16'(TIMEOUT - 1)) begin
                 w_nxt     = S_READ;
                 w_tmo_set = 1'b1;
               end
      S_READ:  if (r_cnt == 16'(RD_W - 1)) w_nxt = S_STORE;
      S_STORE: w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // ADC strobes decoded from the next state and registered, so pins are glitch-free
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_convst_n <= 1'b1; r_cs_n <= 1'b1; r_rd_n <= 1'b1;
    end else begin
      r_convst_n <= (w_nxt != S_CONV);
      r_cs_n     <= (w_nxt != S_READ);
      r_rd_n     <= (w_nxt != S_READ);
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr <= '0; r_rptr <= '0; r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CNTW'(w_push_ok) - CNTW'(w_pop);
    end
  end

  // FIFO storage; contents are don't-care while the count says empty
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= r_sample;
  end

  // zero-wait-state read mux; DATA shows the FIFO head (fall-through)
  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      2'd0: bus.readdata = {29'd0, r_irq_en, 1'b0, r_enable};
      2'd1: bus.readdata = {16'd0, r_period};
      2'd2: bus.readdata = (r_count != '0) ? (32'h8000_0000 | 32'(r_mem[r_rptr])) : 32'd0;
      2'd3: bus.readdata = {21'd0, r_missed, r_tmo, r_ovf, 4'(r_count), 3'd0,
                            (r_state != S_IDLE)};
      default: bus.readdata = '0;
    endcase
  end
endmodule

// File: tb/tb_kernel_ad_sequencer.sv
// Bench for kernel_ad_sequencer: bus reads queue their expected value on a
// scoreboard; a negedge monitor compares them and models the ADC pins.
module tb_kernel_ad_sequencer;
  localparam int DATA_W = 12, CONV_W = 2, RD_W = 3, TIMEOUT = 255;

  logic clk = 1'b0, reset_n = 1'b0;
  logic ad_convst_n, ad_cs_n, ad_rd_n, irq;
  logic ad_busy = 1'b0;
  logic [DATA_W-1:0] ad_data = '0;

  kernel_ad_sequencer_if bus();

  kernel_ad_sequencer #(.DATA_W(DATA_W), .FIFO_AW(3), .CONV_W(CONV_W),
                        .RD_W(RD_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .ad_convst_n(ad_convst_n), .ad_cs_n(ad_cs_n), .ad_rd_n(ad_rd_n),
    .ad_busy(ad_busy), .ad_data(ad_data), .irq(irq));

  always #5 clk = ~clk;

  typedef struct { logic [31:0] ex; logic [31:0] mask; string name; } exp_t;
  exp_t sb[$];
  exp_t e;
  int npass = 0, ntot = 0, cyc = 0;
  int busy_len = 3, busy_left = 0, conv_cnt = 0, data_base = 0;
  bit busy_stuck = 1'b0;
  int fall_q[$];
  int cv_rise = 0, rd_fall = 0, cv_lo = 0, rd_lo = 0;
  logic prev_cv = 1'b1, prev_rd = 1'b1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] ex);
    ntot++;
    if (act === ex) npass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, ex);
  endfunction

  always @(posedge clk) cyc++;

  // scoreboard monitor + ADC model + strobe width checks
  always @(negedge clk) begin
    if (bus.chipselect && !bus.read_n) begin
      if (sb.size() == 0) begin
        ntot++;
        $display("FAIL stray read: addr %0d with no expected value", bus.address);
      end else begin
        e = sb.pop_front();
        check(e.name, bus.readdata & e.mask, e.ex);
      end
    end
    if (!reset_n) begin
      ad_busy = 1'b0; busy_left = 0; cv_lo = 0; rd_lo = 0;
      prev_cv = 1'b1; prev_rd = 1'b1;
    end else begin
      if (ad_busy && !busy_stuck) begin
        if (busy_left <= 1) ad_busy = 1'b0;
        else busy_left--;
      end
      if (!ad_convst_n) begin
        if (prev_cv) begin
          fall_q.push_back(cyc);
          ad_data = DATA_W'(data_base + conv_cnt);
          conv_cnt++;
          ad_busy = 1'b1;
          busy_left = busy_len;
        end
        cv_lo++;
      end else if (!prev_cv) begin
        check("convst width", cv_lo, CONV_W);
        cv_lo = 0; cv_rise = cyc;
      end
      if (!ad_rd_n) begin
        if (prev_rd) rd_fall = cyc;
        rd_lo++;
      end else if (!prev_rd) begin
        check("rd width", rd_lo, RD_W);
        rd_lo = 0;
      end
      prev_cv = ad_convst_n;
      prev_rd = ad_rd_n;
    end
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    @(posedge clk); #1;
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] ex, input string name,
                    input logic [31:0] mask = 32'hFFFF_FFFF);
    @(posedge clk); #1;
    bus.address = a; bus.chipselect = 1'b1; bus.read_n = 1'b0;
    sb.push_back('{ex, mask, name});
    @(posedge clk); #1;
    bus.chipselect = 1'b0; bus.read_n = 1'b1;
  endtask

  task automatic wait_rd(input logic lvl, input string name);
    int n = 0;
    while (ad_rd_n !== lvl && n < 600) begin @(posedge clk); #1; n++; end
    if (ad_rd_n !== lvl) begin
      ntot++;
      $display("FAIL %s: timed out waiting for ad_rd_n=%0b", name, lvl);
    end
  endtask

  task automatic conv_done(input string name);
    wait_rd(1'b0, name);
    wait_rd(1'b1, name);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int n;
    bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1;
    bus.read_n = 1'b1; bus.writedata = '0;
    repeat (3) @(posedge clk); #1;
    reset_n = 1'b1;

    // reset state
    check("reset pins", {ad_convst_n, ad_cs_n, ad_rd_n, irq}, 32'hE);
    rd(2'd3, 32'h0, "reset status");
    rd(2'd2, 32'h0, "reset data");
    rd(2'd0, 32'h0, "reset ctrl");

    // single shot
    busy_len = 10; data_base = 'hABC - conv_cnt;
    wr(2'd0, 32'h2);
    conv_done("single");
    rd(2'd3, 32'h10, "single count1");
    rd(2'd2, 32'h8000_0ABC, "single data");
    rd(2'd3, 32'h0, "single count0");
    rd(2'd2, 32'h0, "empty data");
    rd(2'd0, 32'h0, "start self-clear");

    // interrupt follows IRQ_EN and FIFO occupancy
    data_base = 'h123 - conv_cnt;
    wr(2'd0, 32'h6);
    conv_done("irq");
    check("irq set", irq, 32'h1);
    rd(2'd2, 32'h8000_0123, "irq data");
    check("irq clear", irq, 32'h0);
    wr(2'd0, 32'h0);

    // periodic mode
    busy_len = 5; data_base = 'h100 - conv_cnt; fall_q.delete();
    wr(2'd1, 32'd100);
    wr(2'd0, 32'h1);
    n = 0;
    while (fall_q.size() < 3 && n < 400) begin @(posedge clk); n++; end
    wr(2'd0, 32'h0);
    if (fall_q.size() >= 3) begin
      check("period gap1", fall_q[1] - fall_q[0], 32'd100);
      check("period gap2", fall_q[2] - fall_q[1], 32'd100);
    end else begin
      ntot++;
      $display("FAIL periodic: only %0d convst edges, expected 3", fall_q.size());
    end
    conv_done("periodic");
    rd(2'd3, 32'h30, "periodic status");
    for (int i = 0; i < 3; i++) rd(2'd2, 32'h8000_0100 + i, "periodic data");

    // overflow: 9 conversions, no reads
    busy_len = 3; data_base = 'h200 - conv_cnt;
    repeat (9) begin wr(2'd0, 32'h2); conv_done("ovf"); end
    rd(2'd3, 32'h180, "ovf status");
    for (int i = 0; i < 8; i++) rd(2'd2, 32'h8000_0200 + i, "ovf data");
    rd(2'd3, 32'h100, "ovf drained");
    wr(2'd3, 32'h100);
    rd(2'd3, 32'h0, "ovf cleared");

    // BUSY stuck high -> timeout
    busy_stuck = 1'b1; data_base = 'h3C3 - conv_cnt;
    wr(2'd0, 32'h2);
    conv_done("timeout");
    check("timeout wait", rd_fall - cv_rise, TIMEOUT);
    busy_stuck = 1'b0;
    rd(2'd3, 32'h210, "timeout status");
    rd(2'd2, 32'h8000_03C3, "timeout data");
    wr(2'd3, 32'h200);
    rd(2'd3, 32'h0, "timeout cleared");

    // triggers during a long conversion are missed
    busy_len = 20;
    wr(2'd1, 32'd4);
    wr(2'd0, 32'h1);
    repeat (60) @(posedge clk);
    wr(2'd0, 32'h0);
    repeat (60) @(posedge clk);
    rd(2'd3, 32'h400, "missed sticky", 32'h700);
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    reset_n = 1'b1;

    // push and pop on the same edge while full
    busy_len = 3; data_base = 'h400 - conv_cnt;
    repeat (8) begin wr(2'd0, 32'h2); conv_done("fill"); end
    rd(2'd3, 32'h80, "full status");
    wr(2'd0, 32'h2);
    wait_rd(1'b0, "sim");
    repeat (2) @(posedge clk);
    rd(2'd2, 32'h8000_0400, "sim pop head");
    repeat (2) @(posedge clk);
    rd(2'd3, 32'h80, "sim count stays 8");
    for (int i = 1; i <= 8; i++) rd(2'd2, 32'h8000_0400 + i, "sim data");
    rd(2'd3, 32'h0, "sim drained");

    // reset in the middle of READ
    wr(2'd0, 32'h2);
    wait_rd(1'b0, "rst mid read");
    reset_n = 1'b0;
    #1;
    check("reset abort pins", {ad_convst_n, ad_cs_n, ad_rd_n}, 32'h7);
    repeat (2) @(posedge clk); #1;
    reset_n = 1'b1;
    rd(2'd3, 32'h0, "post-reset status");
    rd(2'd2, 32'h0, "post-reset data");

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
